// File: rtl/axi_ar_delay_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_ar_delay_fifo                                                          |
// | In-order AXI AR buffer; cacheable requests inside a programmable address   |
// | window are held for cfg_delay cycles. Optional combinational bypass for    |
// | an empty FIFO: define AXI_AR_DLY_BYPASS_EN.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axi_ar_delay_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 40,
    parameter int ID_W   = 8,
    parameter int DLY_W  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_b,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [1:0]        s_arburst,
    input  logic [3:0]        s_arcache,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [7:0]        s_arlen,
    input  logic              s_arlock,
    input  logic [2:0]        s_arprot,
    input  logic [2:0]        s_arsize,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [1:0]        m_arburst,
    output logic [3:0]        m_arcache,
    output logic [ID_W-1:0]   m_arid,
    output logic [7:0]        m_arlen,
    output logic              m_arlock,
    output logic [2:0]        m_arprot,
    output logic [2:0]        m_arsize,
    output logic              m_artrust,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic              cfg_dly_en,
    input  logic [ADDR_W-1:0] cfg_win_lo,
    input  logic [ADDR_W-1:0] cfg_win_hi,
    input  logic [DLY_W-1:0]  cfg_delay,
    output logic [CNT_W-1:0]  fifo_cnt,
    output logic              fifo_full,
    output logic              fifo_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int PAY_W = ADDR_W + ID_W + 21;

    logic [PAY_W-1:0] r_pay [DEPTH];
    logic             r_vld [DEPTH];
    logic [DLY_W-1:0] r_dly [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_hit;
    logic             w_push;
    logic             w_pop;
    logic             w_head_rdy;
    logic [PAY_W-1:0] w_s_pay;
    logic [PAY_W-1:0] w_out_pay;

    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign w_empty = (r_cnt == '0);

    // Unsigned inclusive window; lo > hi naturally yields no hits.
    assign w_hit = cfg_dly_en && s_arcache[1]
                 && (s_araddr >= cfg_win_lo) && (s_araddr <= cfg_win_hi);

    assign w_s_pay    = {s_araddr, s_arburst, s_arcache, s_arid,
                         s_arlen, s_arlock, s_arprot, s_arsize};
    assign w_head_rdy = r_vld[r_rptr] && (r_dly[r_rptr] == '0);
    assign w_pop      = w_head_rdy && m_arready;

    // Ready is a function of registered occupancy only.
    assign s_arready = !w_full;

`ifdef AXI_AR_DLY_BYPASS_EN
    logic w_byp;

    // An empty FIFO can always absorb a stalled bypass request, so ready
    // stays high and the request is captured only when downstream stalls.
    assign w_byp     = cpu_rst_b && w_empty && !w_hit;
    assign w_push    = s_arvalid && !w_full && !(w_byp && m_arready);
    assign m_arvalid = w_byp ? s_arvalid : w_head_rdy;
    assign w_out_pay = w_byp ? w_s_pay : r_pay[r_rptr];
`else
    assign w_push    = s_arvalid && !w_full;
    assign m_arvalid = w_head_rdy;
    assign w_out_pay = r_pay[r_rptr];
`endif

    assign {m_araddr, m_arburst, m_arcache, m_arid,
            m_arlen, m_arlock, m_arprot, m_arsize} = w_out_pay;
    assign m_artrust  = 1'b0;
    assign fifo_cnt   = r_cnt;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic w_wr;
        logic w_rd;

        assign w_wr = w_push && (r_wptr == PTR_W'(gi));
        assign w_rd = w_pop && (r_rptr == PTR_W'(gi));

        // Every entry counts down on its own, regardless of head position.
        always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
            if (!cpu_rst_b) begin
                r_vld[gi] <= 1'b0;
                r_dly[gi] <= '0;
                r_pay[gi] <= '0;
            end else if (w_wr) begin
                r_vld[gi] <= 1'b1;
                r_dly[gi] <= w_hit ? cfg_delay : '0;
                r_pay[gi] <= w_s_pay;
            end else begin
                if (w_rd) begin
                    r_vld[gi] <= 1'b0;
                end
                if (r_vld[gi] && (r_dly[gi] != '0)) begin
                    r_dly[gi] <= r_dly[gi] - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_ar_delay_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_ar_delay_fifo                                                       |
// | Scoreboard bench for axi_ar_delay_fifo (default build).                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axi_ar_delay_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 40;
    localparam int ID_W   = 8;
    localparam int DLY_W  = 16;
    localparam int CNT_W  = 4;

    logic              cpu_clk = 1'b0;
    logic              cpu_rst_b = 1'b0;
    logic [ADDR_W-1:0] s_araddr = '0;
    logic [1:0]        s_arburst = 2'b01;
    logic [3:0]        s_arcache = '0;
    logic [ID_W-1:0]   s_arid = '0;
    logic [7:0]        s_arlen = '0;
    logic              s_arlock = 1'b0;
    logic [2:0]        s_arprot = 3'b010;
    logic [2:0]        s_arsize = 3'b011;
    logic              s_arvalid = 1'b0;
    logic              s_arready;
    logic [ADDR_W-1:0] m_araddr;
    logic [1:0]        m_arburst;
    logic [3:0]        m_arcache;
    logic [ID_W-1:0]   m_arid;
    logic [7:0]        m_arlen;
    logic              m_arlock;
    logic [2:0]        m_arprot;
    logic [2:0]        m_arsize;
    logic              m_artrust;
    logic              m_arvalid;
    logic              m_arready = 1'b1;
    logic              cfg_dly_en = 1'b0;
    logic [ADDR_W-1:0] cfg_win_lo = '0;
    logic [ADDR_W-1:0] cfg_win_hi = '0;
    logic [DLY_W-1:0]  cfg_delay = '0;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;

    axi_ar_delay_fifo #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ID_W(ID_W), .DLY_W(DLY_W), .CNT_W(CNT_W)
    ) u_dut (
        .cpu_clk(cpu_clk), .cpu_rst_b(cpu_rst_b),
        .s_araddr(s_araddr), .s_arburst(s_arburst), .s_arcache(s_arcache),
        .s_arid(s_arid), .s_arlen(s_arlen), .s_arlock(s_arlock),
        .s_arprot(s_arprot), .s_arsize(s_arsize), .s_arvalid(s_arvalid),
        .s_arready(s_arready),
        .m_araddr(m_araddr), .m_arburst(m_arburst), .m_arcache(m_arcache),
        .m_arid(m_arid), .m_arlen(m_arlen), .m_arlock(m_arlock),
        .m_arprot(m_arprot), .m_arsize(m_arsize), .m_artrust(m_artrust),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .cfg_dly_en(cfg_dly_en), .cfg_win_lo(cfg_win_lo), .cfg_win_hi(cfg_win_hi),
        .cfg_delay(cfg_delay),
        .fifo_cnt(fifo_cnt), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        int                rdy;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;

    always @(posedge cpu_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_dly(input logic [ADDR_W-1:0] addr, input logic [3:0] cache);
        if (cfg_dly_en && cache[1] && addr >= cfg_win_lo && addr <= cfg_win_hi)
            return int'(cfg_delay);
        return 0;
    endfunction

    task automatic sb_push(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [3:0] cache);
        sb_t e;
        e.id   = id;
        e.addr = addr;
        e.rdy  = cyc + 1 + model_dly(addr, cache);
        sb_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                        input logic [3:0] cache, output int ncyc);
        bit ok = 1'b0;
        s_arid = id; s_araddr = addr; s_arcache = cache; s_arlen = id; s_arvalid = 1'b1;
        ncyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge cpu_clk);
            if (s_arready) begin
                ncyc = cyc;
                sb_push(id, addr, cache);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("push_timeout", 64'd0, 64'd1);
        @(posedge cpu_clk); #1;
    endtask

    task automatic wait_valid(output int vcyc);
        vcyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge cpu_clk);
            if (m_arvalid) begin
                vcyc = cyc;
                break;
            end
        end
    endtask

    task automatic lat(input string tag, input logic [ID_W-1:0] id,
                       input logic [ADDR_W-1:0] addr, input logic [3:0] cache, input int d);
        int n, v;
        push(id, addr, cache, n);
        s_arvalid = 1'b0;
        wait_valid(v);
        check(tag, 64'(v), 64'(n + 1 + d));
        @(posedge cpu_clk); #1;
    endtask

    task automatic drain();
        m_arready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge cpu_clk);
            if (sb_q.size() == 0 && fifo_empty) break;
        end
        check("drain_sb_empty", 64'(sb_q.size()), 64'd0);
        @(posedge cpu_clk); #1;
    endtask

    // Output monitor: AXI hold rule plus in-order scoreboard compare.
    logic              pv = 1'b0;
    logic [ADDR_W-1:0] pa = '0;
    always @(negedge cpu_clk) begin
        sb_t e;
        if (!cpu_rst_b) begin
            pv = 1'b0;
        end else begin
            if (pv) begin
                check("hold_valid", 64'(m_arvalid), 64'd1);
                check("hold_addr", 64'(m_araddr), 64'(pa));
            end
            if (m_arvalid && m_arready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("pop_id", 64'(m_arid), 64'(e.id));
                    check("pop_addr", 64'(m_araddr), 64'(e.addr));
                    check("pop_len", 64'(m_arlen), 64'(e.id));
                    check("pop_not_early", 64'(cyc >= e.rdy), 64'd1);
                end
            end
            pv = m_arvalid && !m_arready;
            pa = m_araddr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, v;

        // Reset with a request held on the input
        s_arvalid = 1'b1; s_araddr = 40'h1234; s_arcache = 4'b0010;
        repeat (3) @(posedge cpu_clk);
        #1 cpu_rst_b = 1'b1;
        @(negedge cpu_clk);
        check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        check("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
        check("rst_s_arready", 64'(s_arready), 64'd1);
        check("rst_empty", 64'(fifo_empty), 64'd1);
        check("rst_full", 64'(fifo_full), 64'd0);
        check("rst_m_araddr", 64'(m_araddr), 64'd0);
        check("rst_m_artrust", 64'(m_artrust), 64'd0);
        s_arvalid = 1'b0;
        @(posedge cpu_clk); #1;

        // Window hit latency and boundary cases
        cfg_dly_en = 1'b1; cfg_win_lo = 40'h0; cfg_win_hi = 40'h1FFFF; cfg_delay = 16'd5;
        lat("lat_hit_d5", 8'h01, 40'h100, 4'b0010, 5);
        lat("lat_hit_win_hi", 8'h02, 40'h1FFFF, 4'b0010, 5);
        lat("lat_miss_above_hi", 8'h03, 40'h20000, 4'b0010, 0);
        lat("lat_miss_nocache", 8'h04, 40'h100, 4'b0001, 0);
        cfg_dly_en = 1'b0;
        lat("lat_dly_disabled", 8'h05, 40'h100, 4'b0010, 0);
        cfg_dly_en = 1'b1; cfg_win_lo = 40'h2000; cfg_win_hi = 40'h1000;
        lat("lat_empty_window", 8'h06, 40'h1800, 4'b0010, 0);

        // Miss behind a delayed hit keeps order
        cfg_win_lo = 40'h0; cfg_win_hi = 40'h1FFFF; cfg_delay = 16'd10;
        push(8'h30, 40'h400, 4'b0010, n);
        push(8'h31, 40'h80000, 4'b0010, v);
        s_arvalid = 1'b0;
        wait_valid(v);
        check("order_hit_lat", 64'(v), 64'(n + 11));
        check("order_head_id", 64'(m_arid), 64'h30);
        drain();

        // Fill to full, then pop with a request pending
        m_arready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(8'h40 + 8'(i), 40'h90000 + 40'(i), 4'b0000, n);
        s_arvalid = 1'b0;
        @(negedge cpu_clk);
        check("full_flag", 64'(fifo_full), 64'd1);
        check("full_s_arready", 64'(s_arready), 64'd0);
        check("full_cnt", 64'(fifo_cnt), 64'd8);
        @(posedge cpu_clk); #1;
        s_arid = 8'h48; s_araddr = 40'h90008; s_arcache = 4'b0000; s_arlen = 8'h48;
        s_arvalid = 1'b1; m_arready = 1'b1;
        @(negedge cpu_clk);
        check("full_pop_no_ready", 64'(s_arready), 64'd0);
        @(posedge cpu_clk); #1;
        m_arready = 1'b0;
        @(negedge cpu_clk);
        check("after_pop_cnt", 64'(fifo_cnt), 64'd7);
        check("after_pop_ready", 64'(s_arready), 64'd1);
        if (s_arready) sb_push(8'h48, 40'h90008, 4'b0000);
        @(posedge cpu_clk); #1;
        s_arvalid = 1'b0;
        @(negedge cpu_clk);
        check("refill_cnt", 64'(fifo_cnt), 64'd8);
        check("refill_full", 64'(fifo_full), 64'd1);
        @(posedge cpu_clk); #1;
        drain();

        // Delay is captured at push
        cfg_delay = 16'd3;
        push(8'h50, 40'h200, 4'b0010, n);
        s_arvalid = 1'b0;
        cfg_delay = 16'd20;
        wait_valid(v);
        check("cfg_captured_lat", 64'(v), 64'(n + 4));
        drain();

        // Reset mid-operation discards buffered requests
        cfg_delay = 16'd10; m_arready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i), 40'h300 + 40'(i), 4'b0010, n);
        s_arvalid = 1'b0;
        check("pre_rst_cnt", 64'(fifo_cnt), 64'd4);
        @(posedge cpu_clk); #2;
        cpu_rst_b = 1'b0;
        #1;
        sb_q.delete();
        check("mid_rst_m_arvalid", 64'(m_arvalid), 64'd0);
        check("mid_rst_cnt", 64'(fifo_cnt), 64'd0);
        check("mid_rst_empty", 64'(fifo_empty), 64'd1);
        check("mid_rst_s_arready", 64'(s_arready), 64'd1);
        check("mid_rst_m_araddr", 64'(m_araddr), 64'd0);
        check("mid_rst_m_arid", 64'(m_arid), 64'd0);
        @(posedge cpu_clk); #1;
        cpu_rst_b = 1'b1;
        m_arready = 1'b1;
        lat("post_rst_first_push", 8'h77, 40'h80000, 4'b0010, 0);
        drain();
        check("final_empty", 64'(fifo_empty), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
